// File: rtl/gf967_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : gf967_seq_mul
// Description : Iterative shift-add multiplier for GF(967) coefficients,
//               residue (< Q) times a B_W-bit scalar, exact P_W-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module gf967_seq_mul #(
    parameter int Q   = 967,
    parameter int A_W = 10,
    parameter int B_W = 9,
    parameter int P_W = 19
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_prod,
    output logic           out_err
);

    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam logic [A_W-1:0]   C_Q        = A_W'(Q);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(B_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [P_W-1:0]   r_acc;
    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [P_W-1:0]   r_out_prod;
    logic             r_out_err;
    logic [P_W-1:0]   w_partial;

    assign w_partial = P_W'(r_a) << r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_err      <= (in_a >= C_Q);
                        r_in_ready <= 1'b0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Fixed B_W iterations so latency never depends on the operand value.
                    if (r_b[0]) begin
                        r_acc <= r_acc + w_partial;
                    end
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + C_CNT_ONE;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // First HOLD cycle loads the output flops from the settled accumulator.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_prod  <= r_err ? '0 : r_acc;
                        r_out_err   <= r_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_gf967_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf967_seq_mul
// Description : Self-checking bench for gf967_seq_mul with a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf967_seq_mul;

    localparam int Q   = 967;
    localparam int A_W = 10;
    localparam int B_W = 9;
    localparam int P_W = 19;
    localparam int LAT = B_W + 2;   // accept-cycle sample to first out_valid sample

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [A_W-1:0] in_a = '0;
    logic [B_W-1:0] in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [P_W-1:0] out_prod;
    logic           out_err;

    gf967_seq_mul #(.Q(Q), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned prod;
        int unsigned err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [P_W-1:0] prev_prod = '0;
    logic        prev_err = 1'b0;
    logic        have_last = 1'b0;
    int          last_acc = 0;
    logic        rand_on = 1'b0;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned model_prod(int unsigned a, int unsigned b);
        return (a >= Q) ? 0 : a * b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: samples mid-cycle, scoreboard fed from observed accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_prod", out_prod, 0);
            check("rst_out_err", out_err, 0);
            sb.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            have_last  = 1'b0;
        end else begin
            if (out_valid) begin
                check("busy_in_ready", in_ready, 0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", out_valid, 0);
                    end else begin
                        check("sb_prod", out_prod, sb[0].prod);
                        check("sb_err", out_err, sb[0].err);
                        check("latency", cyc - sb[0].cyc, LAT);
                    end
                end else if (prev_hs) begin
                    check("valid_after_handshake", out_valid, 0);
                end else begin
                    check("stable_prod", out_prod, prev_prod);
                    check("stable_err", out_err, prev_err);
                end
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
            end else if (prev_valid && !prev_hs) begin
                check("valid_dropped_early", out_valid, 1);
            end
            if (in_valid && in_ready) begin
                if (have_last) check("accept_spacing_ok", (cyc - last_acc) >= LAT, 1);
                sb.push_back('{model_prod(in_a, in_b), (in_a >= Q), cyc});
                have_last = 1'b1;
                last_acc  = cyc;
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_prod  = out_prod;
            prev_err   = out_err;
        end
    end

    task automatic do_op(input int a, input int b, input int stall,
                         output int unsigned prod, output int unsigned err);
        int n;
        @(posedge clk); #1;
        in_a = A_W'(a);
        in_b = B_W'(b);
        in_valid = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        check("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check("result_timeout", out_valid, 1);
        prod = out_prod;
        err  = out_err;
        if (stall > 0) begin
            repeat (stall - 1) @(negedge clk);
            check("stall_valid_held", out_valid, 1);
            check("stall_prod_held", out_prod, prod);
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            check("handshake_cycle_valid", out_valid, 1);
            check("handshake_cycle_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int unsigned p, e;
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_first_edge", in_ready, 0);

        do_op(966, 511, 0, p, e);
        check("t1_prod", p, 493626); check("t1_err", e, 0);
        do_op(0, 300, 0, p, e);   check("t2a_prod", p, 0);
        do_op(483, 2, 0, p, e);   check("t2b_prod", p, 966);
        do_op(1, 1, 0, p, e);     check("t2c_prod", p, 1);
        do_op(500, 400, 6, p, e); check("t3_prod", p, 200000); check("t3_err", e, 0);
        do_op(967, 5, 0, p, e);   check("t4a_prod", p, 0); check("t4a_err", e, 1);
        do_op(2, 3, 0, p, e);     check("t4b_prod", p, 6); check("t4b_err", e, 0);

        // Reset during the multiply: partial product must never surface.
        @(posedge clk); #1;
        in_a = 10'd100; in_b = 9'd100; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_prod", out_prod, 0);
        check("t5_async_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready_after_release", in_ready, 0);
        @(negedge clk);
        check("t5_in_ready_first_edge", in_ready, 1);
        repeat (15) @(negedge clk);
        check("t5_no_product", out_valid, 0);
        do_op(10, 10, 0, p, e);   check("t5_prod", p, 100);

        // Operand stream with in_valid held high and random backpressure.
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                if (rand_on) out_ready = 1'($urandom % 2);
            end
        join_none
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            in_a = A_W'($urandom_range(0, 1023));
            in_b = B_W'($urandom_range(0, 511));
            in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 80) begin @(negedge clk); n++; end
            check("stream_accept_timeout", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
        check("stream_drain", sb.size(), 0);
        rand_on = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
